// File: rtl/pass_check.sv
// -----------------------------------------------------------------------------
// pass_check
//
// Collects a 4-digit code (one nibble per confirm push), compares it with the
// stored password, and then either opens (timed unlock pulse) or records a
// failed attempt.  The entry buffer is also exported for the 7-segment path,
// with 4'hF marking digits that have not been entered yet.
//
// Optional feature macro: PASS_LOCKOUT_EN
//   defined   - MAX_TRIES consecutive wrong codes enter a timed lockout
//   undefined - lockout never happens and 'locked' is tied low
//
// Parameters:
//   UNLOCK_CYCLES - cycles 'unlock' stays high after a match (>= 1)
//   LOCK_CYCLES   - cycles spent in lockout (>= 1)
//   MAX_TRIES     - consecutive wrong codes that trigger lockout (1..7)
//
// Ports:
//   clk_in      in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   push_pulse  in   one-cycle confirm pulse
//   value_4bit  in   digit presented for capture
//   password    in   stored 16-bit password
//   set_busy    in   password setter busy; aborts entry/unlock
//   unlock      out  high while open
//   locked      out  high while locked out
//   fail_pulse  out  one-cycle pulse per wrong code
//   digit_cnt   out  digits captured so far (0..4)
//   wrong_cnt   out  consecutive wrong codes (saturates at 7)
//   disp_code   out  entry buffer, unfilled nibbles read 4'hF
// -----------------------------------------------------------------------------
module pass_check #(
    parameter int UNLOCK_CYCLES = 8,
    parameter int LOCK_CYCLES   = 16,
    parameter int MAX_TRIES     = 3
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        push_pulse,
    input  logic [3:0]  value_4bit,
    input  logic [15:0] password,
    input  logic        set_busy,
    output logic        unlock,
    output logic        locked,
    output logic        fail_pulse,
    output logic [2:0]  digit_cnt,
    output logic [2:0]  wrong_cnt,
    output logic [15:0] disp_code
);

    localparam int TMAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // Elaboration-time sanity check of the parameter ranges.
    generate
        if (UNLOCK_CYCLES < 1 || LOCK_CYCLES < 1 || MAX_TRIES < 1 || MAX_TRIES > 7) begin : g_bad_param
            $error("pass_check: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        COMPARE = 2'd1,
        OPEN    = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [2:0]      wrong_next;

    // Saturating increment of the wrong-attempt counter.
    assign wrong_next = (wrong_cnt == 3'd7) ? 3'd7 : wrong_cnt + 3'd1;

`ifndef PASS_LOCKOUT_EN
    assign locked = 1'b0;
`endif

    // Main controller.  The timer reloads on entry to OPEN/LOCKED and the state
    // leaves on the edge where it would have reached zero, so the output is high
    // for exactly the loaded number of cycles.  A push arriving on that leaving
    // edge is already accepted as the first digit of a new entry.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= ENTRY;
            timer      <= '0;
            unlock     <= 1'b0;
`ifdef PASS_LOCKOUT_EN
            locked     <= 1'b0;
`endif
            fail_pulse <= 1'b0;
            digit_cnt  <= 3'd0;
            wrong_cnt  <= 3'd0;
            disp_code  <= 16'hFFFF;
        end else begin
            fail_pulse <= 1'b0;
            case (state)
                ENTRY: begin
                    if (set_busy) begin
                        disp_code <= 16'hFFFF;
                        digit_cnt <= 3'd0;
                    end else if (push_pulse) begin
                        disp_code[{digit_cnt[1:0], 2'b00} +: 4] <= value_4bit;
                        digit_cnt <= digit_cnt + 3'd1;
                        if (digit_cnt == 3'd3) begin
                            state <= COMPARE;
                        end
                    end
                end

                COMPARE: begin
                    disp_code <= 16'hFFFF;
                    digit_cnt <= 3'd0;
                    if (set_busy) begin
                        state <= ENTRY;
                    end else if (disp_code == password) begin
                        state     <= OPEN;
                        unlock    <= 1'b1;
                        wrong_cnt <= 3'd0;
                        timer     <= TW'(UNLOCK_CYCLES);
                    end else begin
                        fail_pulse <= 1'b1;
                        wrong_cnt  <= wrong_next;
`ifdef PASS_LOCKOUT_EN
                        if (wrong_next == 3'(MAX_TRIES)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            timer  <= TW'(LOCK_CYCLES);
                        end else begin
                            state <= ENTRY;
                        end
`else
                        state <= ENTRY;
`endif
                    end
                end

                OPEN: begin
                    if (set_busy) begin
                        state     <= ENTRY;
                        unlock    <= 1'b0;
                        timer     <= '0;
                        disp_code <= 16'hFFFF;
                        digit_cnt <= 3'd0;
                    end else if (timer <= TW'(1)) begin
                        state  <= ENTRY;
                        unlock <= 1'b0;
                        timer  <= '0;
                        if (push_pulse) begin
                            disp_code[3:0] <= value_4bit;
                            digit_cnt      <= 3'd1;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

`ifdef PASS_LOCKOUT_EN
                // The setter is deliberately ignored here so a lockout cannot
                // be cut short by starting a password change.
                LOCKED: begin
                    if (timer <= TW'(1)) begin
                        state     <= ENTRY;
                        locked    <= 1'b0;
                        wrong_cnt <= 3'd0;
                        timer     <= '0;
                        if (push_pulse) begin
                            disp_code[3:0] <= value_4bit;
                            digit_cnt      <= 3'd1;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
`endif

                default: begin
                    state  <= ENTRY;
                    unlock <= 1'b0;
                    timer  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pass_check.sv
// -----------------------------------------------------------------------------
// tb_pass_check
//
// Self-checking bench for pass_check.  A behavioural model (digit queue plus
// remaining-cycle counters) tracks what every output must be; a compare
// process checks the DUT against it on each falling edge.  Directed sequences
// add hand-computed literal expectations, then a long randomized phase runs.
// Honours PASS_LOCKOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_pass_check;

    localparam int UNLOCK = 8;
    localparam int LOCK   = 16;
    localparam int MAXT   = 3;
`ifdef PASS_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst;
    logic        push_pulse;
    logic [3:0]  value_4bit;
    logic [15:0] password;
    logic        set_busy;
    logic        unlock;
    logic        locked;
    logic        fail_pulse;
    logic [2:0]  digit_cnt;
    logic [2:0]  wrong_cnt;
    logic [15:0] disp_code;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    logic [3:0] m_digits[$];
    int         m_open;
    int         m_lock;
    int         m_wrong;
    bit         m_cmp;
    bit         m_fail;

    pass_check #(
        .UNLOCK_CYCLES(UNLOCK),
        .LOCK_CYCLES  (LOCK),
        .MAX_TRIES    (MAXT)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .push_pulse(push_pulse),
        .value_4bit(value_4bit),
        .password  (password),
        .set_busy  (set_busy),
        .unlock    (unlock),
        .locked    (locked),
        .fail_pulse(fail_pulse),
        .digit_cnt (digit_cnt),
        .wrong_cnt (wrong_cnt),
        .disp_code (disp_code)
    );

    initial forever #5 clk_in = ~clk_in;

    // Buffer as the display should see it: entered digits, rest 4'hF.
    function automatic logic [15:0] model_disp();
        logic [15:0] v;
        v = 16'hFFFF;
        for (int i = 0; i < m_digits.size(); i++) begin
            v[i*4 +: 4] = m_digits[i];
        end
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, actual, expected);
        end
    endtask

    // Reference model, advanced on every rising edge from the same inputs.
    always @(posedge clk_in) begin : model_step
        logic [15:0] code;
        if (rst) begin
            m_digits.delete();
            m_open  = 0;
            m_lock  = 0;
            m_wrong = 0;
            m_cmp   = 1'b0;
            m_fail  = 1'b0;
        end else begin
            m_fail = 1'b0;
            if (m_lock > 0) begin
                m_lock--;
                if (m_lock == 0) begin
                    m_wrong = 0;
                    if (push_pulse) m_digits.push_back(value_4bit);
                end
            end else if (m_cmp) begin
                m_cmp = 1'b0;
                code  = model_disp();
                m_digits.delete();
                if (!set_busy) begin
                    if (code == password) begin
                        m_open  = UNLOCK;
                        m_wrong = 0;
                    end else begin
                        m_fail = 1'b1;
                        if (m_wrong < 7) m_wrong++;
                        if (LOCKOUT && m_wrong == MAXT) m_lock = LOCK;
                    end
                end
            end else if (set_busy) begin
                m_digits.delete();
                m_open = 0;
            end else if (m_open > 0) begin
                m_open--;
                if (m_open == 0 && push_pulse) m_digits.push_back(value_4bit);
            end else if (push_pulse) begin
                m_digits.push_back(value_4bit);
                if (m_digits.size() == 4) m_cmp = 1'b1;
            end
        end
    end

    // Compare process: every falling edge once the bench is out of power-up.
    always @(negedge clk_in) begin
        if (check_en) begin
            check_output("model.unlock",     32'(unlock),     32'(m_open > 0));
            check_output("model.locked",     32'(locked),     32'(m_lock > 0));
            check_output("model.fail_pulse", 32'(fail_pulse), 32'(m_fail));
            check_output("model.digit_cnt",  32'(digit_cnt),  32'(m_digits.size()));
            check_output("model.wrong_cnt",  32'(wrong_cnt),  32'(m_wrong));
            check_output("model.disp_code",  32'(disp_code),  32'(model_disp()));
        end
    end

    // Drive one cycle of inputs at a falling edge and wait for the next one.
    task automatic apply_stimulus(input bit p, input logic [3:0] v, input bit b, input bit r);
        push_pulse = p;
        value_4bit = v;
        set_busy   = b;
        rst        = r;
        @(negedge clk_in);
        push_pulse = 1'b0;
        set_busy   = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, code[i*4 +: 4], 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, ".unlock"},     32'(unlock),     32'd0);
        check_output({tag, ".locked"},     32'(locked),     32'd0);
        check_output({tag, ".fail_pulse"}, 32'(fail_pulse), 32'd0);
        check_output({tag, ".digit_cnt"},  32'(digit_cnt),  32'd0);
        check_output({tag, ".wrong_cnt"},  32'(wrong_cnt),  32'd0);
        check_output({tag, ".disp_code"},  32'(disp_code),  32'hFFFF);
    endtask

    initial begin
        logic [15:0] pw;
        logic [3:0]  v;
        int          idx;
        rst        = 1'b1;
        push_pulse = 1'b0;
        value_4bit = 4'h0;
        set_busy   = 1'b0;
        password   = 16'h4321;
        @(negedge clk_in);
        check_reset_values("reset");
        check_en = 1'b1;
        rst      = 1'b0;

        // Correct code
        apply_stimulus(1'b1, 4'h1, 1'b0, 1'b0);
        check_output("entry.disp1", 32'(disp_code), 32'hFFF1);
        apply_stimulus(1'b1, 4'h2, 1'b0, 1'b0);
        check_output("entry.disp2", 32'(disp_code), 32'hFF21);
        apply_stimulus(1'b1, 4'h3, 1'b0, 1'b0);
        check_output("entry.disp3", 32'(disp_code), 32'hF321);
        apply_stimulus(1'b1, 4'h4, 1'b0, 1'b0);
        check_output("entry.disp4", 32'(disp_code), 32'h4321);
        check_output("entry.cnt4",  32'(digit_cnt), 32'd4);
        idle(1);
        check_output("open.rise",   32'(unlock),    32'd1);
        check_output("open.disp",   32'(disp_code), 32'hFFFF);
        idle(7);
        check_output("open.last",   32'(unlock),    32'd1);
        idle(1);
        check_output("open.fall",   32'(unlock),    32'd0);

        // Wrong code
        enter_code(16'h5321);
        idle(1);
        check_output("wrong.fail",  32'(fail_pulse), 32'd1);
        check_output("wrong.cnt",   32'(wrong_cnt),  32'd1);
        check_output("wrong.unlk",  32'(unlock),     32'd0);
        check_output("wrong.digit", 32'(digit_cnt),  32'd0);
        idle(1);
        check_output("wrong.fail0", 32'(fail_pulse), 32'd0);

`ifdef PASS_LOCKOUT_EN
        // Lockout after the third consecutive wrong code
        enter_code(16'h5321);
        idle(1);
        enter_code(16'h5321);
        idle(1);
        check_output("lock.rise",  32'(locked),    32'd1);
        check_output("lock.wcnt",  32'(wrong_cnt), 32'd3);
        for (int i = 0; i < 15; i++) apply_stimulus(1'b1, 4'(i), i[0], 1'b0);
        check_output("lock.last",  32'(locked),    32'd1);
        check_output("lock.digit", 32'(digit_cnt), 32'd0);
        idle(1);
        check_output("lock.fall",  32'(locked),    32'd0);
        check_output("lock.wclr",  32'(wrong_cnt), 32'd0);
        enter_code(16'h4321);
        idle(1);
        check_output("lock.unlk",  32'(unlock),    32'd1);
        idle(8);
`else
        // Without lockout the counter just keeps counting
        for (int i = 0; i < 4; i++) begin
            enter_code(16'h5321);
            idle(1);
        end
        check_output("nolock.locked", 32'(locked),    32'd0);
        check_output("nolock.wcnt",   32'(wrong_cnt), 32'd5);
        enter_code(16'h4321);
        idle(1);
        check_output("nolock.unlk",   32'(unlock),    32'd1);
        check_output("nolock.wclr",   32'(wrong_cnt), 32'd0);
        idle(8);
`endif

        // Abort by setter, concurrent digit dropped
        apply_stimulus(1'b1, 4'h1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'h2, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'h7, 1'b1, 1'b0);
        check_output("abort.digit", 32'(digit_cnt), 32'd0);
        check_output("abort.disp",  32'(disp_code), 32'hFFFF);
        apply_stimulus(1'b1, 4'h9, 1'b0, 1'b0);
        check_output("abort.next",  32'(disp_code), 32'hFFF9);
        apply_stimulus(1'b0, 4'h0, 1'b1, 1'b0);

        // Reset mid-unlock (timer at 3)
        enter_code(16'h4321);
        idle(1);
        idle(5);
        check_output("rstopen.pre", 32'(unlock), 32'd1);
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        check_reset_values("rstopen");

`ifdef PASS_LOCKOUT_EN
        // Reset mid-lockout
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h1111);
            idle(1);
        end
        idle(4);
        check_output("rstlock.pre", 32'(locked), 32'd1);
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        check_reset_values("rstlock");
`endif

        // Randomized phase, digits biased toward the current password
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) password = 16'($urandom);
            pw  = password;
            idx = m_digits.size();
            if (idx < 4 && $urandom_range(0, 3) != 0) v = pw[idx*4 +: 4];
            else v = 4'($urandom);
            apply_stimulus(1'($urandom_range(0, 1)), v,
                           ($urandom_range(0, 24) == 0),
                           ($urandom_range(0, 299) == 0));
        end

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pass_check.md
# pass_check

Downstream consumer of the stored 16-bit password produced by the new-password setter. Collects a 4-digit code entered one nibble per confirm push and compares it against the stored password. On a match it drives a timed unlock pulse; on a mismatch it counts failed attempts and optionally enters a timed lockout. It also drives the code buffer to the 7-segment display path, with 4'hF marking blank digits.

## Interface
- `UNLOCK_CYCLES`, default 8: clock cycles `unlock` stays high after a match (must be ≥1).
- `LOCK_CYCLES`, default 16: clock cycles spent in lockout (must be ≥1).
- `MAX_TRIES`, default 3: consecutive wrong codes that trigger lockout (range 1..7).

Clock and reset are a single clock domain; reset is synchronous and active-high.

- `clk_in` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `push_pulse` in 1: single-cycle confirm pulse from the push detector.
- `value_4bit` in 4: digit presented for capture.
- `password` in 16: stored password from the setter.
- `set_busy` in 1: setter's `disable_cnt`; high while a new password is being written.
- `unlock` out 1: high while in OPEN.
- `locked` out 1: high while in LOCKED.
- `fail_pulse` out 1: one-cycle pulse per wrong code.
- `digit_cnt` out 3: digits captured so far, 0..4.
- `wrong_cnt` out 3: consecutive wrong codes.
- `disp_code` out 16: entry buffer for the display; unfilled nibbles read 4'hF.

## Operation
- States: ENTRY, COMPARE, OPEN, LOCKED. Reset lands in ENTRY.
- Reset values:
  - `disp_code` = 16'hFFFF.
  - `digit_cnt` = 0, `wrong_cnt` = 0.
  - `unlock`, `locked`, `fail_pulse` all 0.
- ENTRY:
  - Each `push_pulse` writes `value_4bit` into nibble `digit_cnt` (first digit goes to [3:0], fourth to [15:12]) and increments `digit_cnt`.
  - The fourth capture moves the state to COMPARE.
- COMPARE (exactly one cycle): the full buffer is compared against `password`.
  - Equal: go to OPEN, clear `wrong_cnt`, load the timer with UNLOCK_CYCLES.
  - Not equal: pulse `fail_pulse` and increment `wrong_cnt` (saturating at 7).
    - If PASS_LOCKOUT_EN is defined and the new `wrong_cnt` equals MAX_TRIES, go to LOCKED and load the timer with LOCK_CYCLES.
    - Otherwise return to ENTRY.
  - On every exit: `disp_code` is set to 16'hFFFF and `digit_cnt` to 0.
- OPEN: the timer counts down; the state returns to ENTRY when it reaches 0.
- LOCKED: the timer counts down; on expiry the state returns to ENTRY and `wrong_cnt` clears.
- `push_pulse` is ignored in COMPARE, OPEN and LOCKED.
- `set_busy` high in ENTRY, COMPARE or OPEN forces the following on the next edge:
  - state = ENTRY;
  - buffer cleared to 16'hFFFF and `digit_cnt` = 0;
  - `unlock` = 0;
  - `wrong_cnt` unchanged.
- `set_busy` is ignored in LOCKED; a lockout cannot be escaped through the setter.
- Simultaneous `set_busy` and `push_pulse`: `set_busy` wins and the digit is dropped.
- `rst` has priority over every other input in every state, including mid-lockout and mid-unlock.

## Timing
- All outputs are registered.
- A push at edge N captures the digit; `disp_code` and `digit_cnt` update at N.
- When edge N captures the fourth digit:
  - COMPARE is active during cycle N..N+1;
  - `unlock` or `fail_pulse` (and `locked` on lockout) rises at edge N+1.
- `unlock` is high for exactly UNLOCK_CYCLES cycles; `locked` is high for exactly LOCK_CYCLES cycles.
- The first push accepted after OPEN or LOCKED is the one at the edge on which that state's output falls.
- `password` is sampled only in the COMPARE cycle. A change at any other time does not affect an entry already in progress until its compare.
- Timer width: $clog2(max(UNLOCK_CYCLES, LOCK_CYCLES)+1) bits.

## Configuration
- `PASS_LOCKOUT_EN` defined:
  - MAX_TRIES consecutive wrong codes enter LOCKED;
  - `locked` is functional.
- Not defined:
  - LOCKED is unreachable and `locked` is tied to 0;
  - `wrong_cnt` still counts, saturates at 7, and clears on a match;
  - the lockout timer load logic is removed.

## Test plan
Benches use the default parameters with `PASS_LOCKOUT_EN` defined, unless noted.

- **Correct code:** `password` = 16'h4321; push digits 1, 2, 3, 4.
  - `disp_code` steps FFF1 → FF21 → F321 → 4321.
  - One cycle after the fourth push, `unlock` = 1 for 8 cycles, then `disp_code` = FFFF.
- **Wrong code:** push 1, 2, 3, 5.
  - `fail_pulse` is high for one cycle; `wrong_cnt` = 1; `unlock` stays 0.
  - `digit_cnt` = 0 afterwards.
- **Lockout:** three wrong codes.
  - `locked` = 1 for 16 cycles; pushes and `set_busy` are ignored throughout.
  - Afterwards `wrong_cnt` = 0, and a correct code unlocks.
- **Abort by setter:** two digits entered, then `set_busy` high for one cycle together with a push.
  - `digit_cnt` = 0, `disp_code` = FFFF, and the concurrent digit is not captured.
- **Reset mid-operation:** assert `rst` during OPEN at timer = 3 and during LOCKED.
  - On the next edge every output is at its reset value.
- **Macro off:** five wrong codes.
  - `locked` never asserts, `wrong_cnt` = 5, and the following correct code unlocks and clears `wrong_cnt`.
